sar_clk_ctrl: RTL and testbench

- Sequencer that sits directly upstream of the SAR clock-path mux.
- Generates the sample phase, the per-bit comparator clock and the mux select.
- Drives the trial DAC code bit by bit, MSB first, and captures the comparator decisions into the conversion result.
- One conversion starts on a start pulse; a one-cycle result_valid strobe marks the end.

---
 rtl/sar_clk_ctrl.sv | 138 +++++++++++++
 tb/tb_sar_clk_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_clk_ctrl.sv
// SAR conversion sequencer: sample phase, per-bit comparator clock, clock-mux select, trial DAC code.
// Optional macro SAR_CLK_CTRL_CONT_EN: start seen in DONE chains straight into the next conversion.
module sar_clk_ctrl #(
    parameter int N_BITS        = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int CMP_PERIOD    = 2,
    parameter int CMP_HIGH      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cmp_out,
    output logic              sample,
    output logic              cmp_clk,
    output logic              mux_sel,
    output logic [N_BITS-1:0] dac_code,
    output logic [N_BITS-1:0] result,
    output logic              result_valid,
    output logic              busy
);

    // state | meaning
    // IDLE  | waiting for start, only result is non-zero
    // SMP   | sample switch closed for SAMPLE_CYCLES cycles
    // CONV  | N_BITS bit periods, MSB first, mux_sel high
    // DONE  | one cycle, result updated and result_valid strobed

    if (N_BITS < 2 || N_BITS > 16 || SAMPLE_CYCLES < 1 || CMP_PERIOD < 2 ||
        CMP_HIGH < 1 || CMP_HIGH > CMP_PERIOD - 1) begin : g_param_check
        $error("sar_clk_ctrl: illegal parameter combination");
    end

    localparam int IW = $clog2(N_BITS);
    localparam int PW = $clog2(CMP_PERIOD);
    localparam int SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

    localparam logic [IW-1:0]     BIT_TOP   = IW'(N_BITS - 1);
    localparam logic [PW-1:0]     PER_LAST  = PW'(CMP_PERIOD - 1);
    localparam logic [PW-1:0]     HIGH_END  = PW'(CMP_HIGH);
    localparam logic [SW-1:0]     SAMP_LAST = SW'(SAMPLE_CYCLES - 1);
    localparam logic [N_BITS-1:0] ONE       = N_BITS'(1);

    typedef enum logic [1:0] {IDLE, SMP, CONV, DONE} state_t;

    state_t             state;
    logic [N_BITS-1:0]  sar;
    logic [N_BITS-1:0]  keep;
    logic [IW-1:0]      bit_idx;
    logic [PW-1:0]      per_cnt;
    logic [PW-1:0]      per_nxt;
    logic [SW-1:0]      samp_cnt;

    // dac_code already holds sar with the trial bit set, so a "keep" decision is just dac_code
    assign keep    = cmp_out ? dac_code : sar;
    assign per_nxt = per_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sar          <= '0;
            bit_idx      <= '0;
            per_cnt      <= '0;
            samp_cnt     <= '0;
            sample       <= 1'b0;
            cmp_clk      <= 1'b0;
            mux_sel      <= 1'b0;
            dac_code     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SMP;
                        sample   <= 1'b1;
                        busy     <= 1'b1;
                        sar      <= '0;
                        samp_cnt <= '0;
                    end
                end
                SMP: begin
                    if (samp_cnt == SAMP_LAST) begin
                        state    <= CONV;
                        sample   <= 1'b0;
                        mux_sel  <= 1'b1;
                        cmp_clk  <= 1'b1;
                        bit_idx  <= BIT_TOP;
                        per_cnt  <= '0;
                        dac_code <= ONE << BIT_TOP;
                    end else begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                CONV: begin
                    if (per_cnt == PER_LAST) begin
                        sar <= keep;
                        if (bit_idx == '0) begin
                            state        <= DONE;
                            result       <= keep;
                            result_valid <= 1'b1;
                            dac_code     <= '0;
                            mux_sel      <= 1'b0;
                            cmp_clk      <= 1'b0;
                        end else begin
                            bit_idx  <= bit_idx - 1'b1;
                            per_cnt  <= '0;
                            cmp_clk  <= 1'b1;
                            dac_code <= keep | (ONE << (bit_idx - 1'b1));
                        end
                    end else begin
                        per_cnt <= per_nxt;
                        cmp_clk <= (per_nxt < HIGH_END);
                    end
                end
                DONE: begin
                    result_valid <= 1'b0;
`ifdef SAR_CLK_CTRL_CONT_EN
                    if (start) begin
                        state    <= SMP;
                        sample   <= 1'b1;
                        sar      <= '0;
                        samp_cnt <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_clk_ctrl.sv
// Scoreboard bench for sar_clk_ctrl: default-parameter DUT plus a slow-comparator variant.
module tb_sar_clk_ctrl;

    localparam int N  = 8;
    localparam int S0 = 4, P0 = 2, H0 = 1;
    localparam int S1 = 2, P1 = 4, H1 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    logic cmp0, cmp1;
    logic smp0, cc0, ms0, rv0, busy0;
    logic smp1, cc1, ms1, rv1, busy1;
    logic [7:0] dac0, res0, dac1, res1;

    int mode0 = 0;
    logic [7:0] tgt0 = 8'h00;
    int cyc = 0;
    int checks = 0;
    int passes = 0;

    sar_clk_ctrl #(.N_BITS(N), .SAMPLE_CYCLES(S0), .CMP_PERIOD(P0), .CMP_HIGH(H0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .cmp_out(cmp0),
        .sample(smp0), .cmp_clk(cc0), .mux_sel(ms0), .dac_code(dac0),
        .result(res0), .result_valid(rv0), .busy(busy0));

    sar_clk_ctrl #(.N_BITS(N), .SAMPLE_CYCLES(S1), .CMP_PERIOD(P1), .CMP_HIGH(H1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .cmp_out(cmp1),
        .sample(smp1), .cmp_clk(cc1), .mux_sel(ms1), .dac_code(dac1),
        .result(res1), .result_valid(rv1), .busy(busy1));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // bench comparator: mode 1 forces "above", mode 2 forces "below"
    always_comb cmp0 = (mode0 == 1) ? 1'b1 : (mode0 == 2) ? 1'b0 : (tgt0 >= dac0);
    always_comb cmp1 = (8'hA5 >= dac1);

    typedef struct packed {
        int          id;
        logic [7:0]  res;
        int          vcyc;
        int          mfirst;
        int          mlast;
        logic [63:0] seq;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // binary search over the code space: each trial adds the next lower weight
    function automatic exp_t model(input int id, input int mode, input logic [7:0] tgt, input int c0);
        exp_t e;
        int s, p, acc, trial;
        s = (id == 1) ? S1 : S0;
        p = (id == 1) ? P1 : P0;
        e = '0;
        acc = 0;
        for (int k = N - 1; k >= 0; k--) begin
            trial = acc + (1 << k);
            e.seq[8*(N-1-k) +: 8] = 8'(trial);
            if (mode == 1 || (mode == 0 && int'(tgt) >= trial)) acc = trial;
        end
        e.id     = id;
        e.res    = 8'(acc);
        e.vcyc   = c0 + s + N * p + 1;
        e.mfirst = c0 + s + 1;
        e.mlast  = c0 + s + N * p;
        return e;
    endfunction

    logic        prev_cc[2];
    int          pulses[2], hw[2], last_rise[2], mfirst[2], mlast[2];
    logic [63:0] seen[2];

    task automatic clear_trk(input int id);
        prev_cc[id]   = 1'b0;
        pulses[id]    = 0;
        hw[id]        = 0;
        last_rise[id] = 0;
        mfirst[id]    = -1;
        mlast[id]     = -1;
        seen[id]      = '0;
    endtask

    task automatic mon_step(input int id, input logic rv, input logic [7:0] res, input logic cc,
                            input logic ms, input logic [7:0] dc);
        exp_t e;
        int p, h;
        p = (id == 1) ? P1 : P0;
        h = (id == 1) ? H1 : H0;
        if (cc && !prev_cc[id]) begin
            if (pulses[id] > 0) chk("cmp_clk period", cyc - last_rise[id], p);
            if (pulses[id] < N) seen[id][8*pulses[id] +: 8] = dc;
            pulses[id]++;
            last_rise[id] = cyc;
            hw[id] = 0;
        end
        if (cc) hw[id]++;
        if (!cc && prev_cc[id]) chk("cmp_clk high width", hw[id], h);
        prev_cc[id] = cc;
        if (ms) begin
            if (mfirst[id] < 0) mfirst[id] = cyc;
            mlast[id] = cyc;
        end
        if (rv) begin
            if (sb.size() == 0 || sb[0].id != id) begin
                chk("unexpected result_valid", cyc, -1);
            end else begin
                e = sb.pop_front();
                chk("result", int'(res), int'(e.res));
                chk("result_valid cycle", cyc, e.vcyc);
                for (int i = 0; i < N; i++)
                    chk("dac_code trial", int'(seen[id][8*i +: 8]), int'(e.seq[8*i +: 8]));
                chk("cmp_clk pulse count", pulses[id], N);
                chk("mux_sel first cycle", mfirst[id], e.mfirst);
                chk("mux_sel last cycle", mlast[id], e.mlast);
                chk("done cmp_clk", int'(cc), 0);
                chk("done mux_sel", int'(ms), 0);
                chk("done dac_code", int'(dc), 0);
            end
            clear_trk(id);
        end
    endtask

    initial begin
        clear_trk(0);
        clear_trk(1);
        forever begin
            @(negedge clk);
            if (rst) clear_trk(0);
            else mon_step(0, rv0, res0, cc0, ms0, dac0);
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) clear_trk(1);
        else mon_step(1, rv1, res1, cc1, ms1, dac1);
    end

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) return;
        end
        chk("conversion timeout, pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic convert(input int id, input int mode, input logic [7:0] tgt);
        @(negedge clk);
        mode0 = mode;
        tgt0  = tgt;
        sb.push_back(model(id, mode, tgt, cyc));
        if (id == 1) start1 = 1'b1;
        else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        wait_done(200);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " sample"}, int'(smp0), 0);
        chk({tag, " cmp_clk"}, int'(cc0), 0);
        chk({tag, " mux_sel"}, int'(ms0), 0);
        chk({tag, " dac_code"}, int'(dac0), 0);
        chk({tag, " result"}, int'(res0), 0);
        chk({tag, " result_valid"}, int'(rv0), 0);
        chk({tag, " busy"}, int'(busy0), 0);
    endtask

    initial begin
        int c0, lows;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        chk("reset dut1 busy", int'(busy1), 0);
        chk("reset dut1 dac_code", int'(dac1), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        convert(0, 0, 8'hA5);
        convert(0, 1, 8'h00);
        convert(0, 2, 8'h00);
        for (int i = 0; i < 6; i++) convert(0, 0, 8'($urandom_range(0, 255)));
        convert(0, 0, 8'h00);
        convert(0, 0, 8'hFF);

        // start held high across a whole conversion
        @(negedge clk);
        c0 = cyc;
        mode0 = 0;
        tgt0 = 8'($urandom_range(0, 255));
`ifdef SAR_CLK_CTRL_CONT_EN
        sb.push_back(model(0, 0, tgt0, c0));
        sb.push_back(model(0, 0, tgt0, c0 + 21));
        sb.push_back(model(0, 0, tgt0, c0 + 42));
        start0 = 1'b1;
        lows = 0;
        for (int i = 1; i <= 63; i++) begin
            @(negedge clk);
            if (!busy0) lows++;
            if (i == 63) start0 = 1'b0;
        end
        wait_done(50);
        chk("busy low cycles in continuous run", lows, 0);
`else
        sb.push_back(model(0, 0, tgt0, c0));
        start0 = 1'b1;
        lows = 0;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            if (i <= 21 && !busy0) lows++;
        end
        #1;
        chk("busy low during held conversion", lows, 0);
        chk("held start pending results", sb.size(), 0);
        chk("busy in cycle 22", int'(busy0), 0);
        sb.push_back(model(0, 0, tgt0, cyc));
        @(negedge clk);
        start0 = 1'b0;
        chk("second start accepted, busy", int'(busy0), 1);
        wait_done(200);
`endif
        repeat (2) @(negedge clk);

        // reset mid-conversion
        @(negedge clk);
        c0 = cyc;
        tgt0 = 8'($urandom_range(0, 255));
        sb.push_back(model(0, 0, tgt0, c0));
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid-conversion mux_sel", int'(ms0), 1);
        rst = 1'b1;
        #1;
        chk_zero("async reset");
        sb.delete();
        clear_trk(0);
        clear_trk(1);
        @(negedge clk);
        rst = 1'b0;
        convert(0, 0, 8'($urandom_range(0, 255)));

        convert(1, 0, 8'hA5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
